// File: rtl/cprv_ram_1p_hs.sv
// Single-port word RAM with byte enables behind a valid/ready request/response handshake.
// One response per accepted request, in order; optional output register stage.
module cprv_ram_1p_hs #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 64,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0,
    localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [BE_WIDTH-1:0]   req_be,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    if ((DATA_WIDTH % 8) != 0) begin : g_width_check
        $error("cprv_ram_1p_hs: DATA_WIDTH must be a multiple of 8");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic                  adv;
    logic                  fire;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] wr_word_d;

    logic                  s1_valid_q;
    logic                  s1_valid_d;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic [DATA_WIDTH-1:0] s1_data_d;

    // The whole pipeline moves as one unit: a stalled output freezes every stage and the array.
    always_comb begin
        adv       = !(rsp_valid && !rsp_ready);
        req_ready = rst_n && adv;
        fire      = req_valid && req_ready;
        mem_we    = fire && req_we;
        old_word  = mem_q[req_addr];
        wr_word_d = old_word;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (req_be[i]) begin
                wr_word_d[8*i +: 8] = req_wdata[8*i +: 8];
            end
        end

        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        if (adv) begin
            s1_valid_d = fire;
            if (fire) begin
                s1_data_d = (req_we && (RDW_MODE == 0)) ? wr_word_d : old_word;
            end
        end
    end

    // Array contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[req_addr] <= wr_word_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic                  s2_valid_q;
        logic                  s2_valid_d;
        logic [DATA_WIDTH-1:0] s2_data_q;
        logic [DATA_WIDTH-1:0] s2_data_d;

        // Data is only captured alongside a valid entry so idle cycles keep the last response.
        always_comb begin
            s2_valid_d = s2_valid_q;
            s2_data_d  = s2_data_q;
            if (adv) begin
                s2_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_d = s1_data_q;
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_valid_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s2_valid_d;
                s2_data_q  <= s2_data_d;
            end
        end

        assign rsp_valid = s2_valid_q;
        assign rsp_rdata = s2_data_q;
    end else begin : g_no_out_reg
        assign rsp_valid = s1_valid_q;
        assign rsp_rdata = s1_data_q;
    end

endmodule

// File: tb/tb_cprv_ram_1p_hs.sv
// Bench for cprv_ram_1p_hs: instance 0 is write-first/no output reg, instance 1 is read-first/output reg.
// A word-array model with an ordered expectation queue per instance scores every response.
module tb_cprv_ram_1p_hs;

    localparam int AW    = 7;
    localparam int DW    = 64;
    localparam int BW    = DW / 8;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rst_n;

    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [1:0]         req_we;
    logic [1:0][AW-1:0] req_addr;
    logic [1:0][BW-1:0] req_be;
    logic [1:0][DW-1:0] req_wdata;
    logic [1:0]         rsp_valid;
    logic [1:0]         rsp_ready;
    logic [1:0][DW-1:0] rsp_rdata;

    cprv_ram_1p_hs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RDW_MODE(0), .OUT_REG(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_be(req_be[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0])
    );

    cprv_ram_1p_hs #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RDW_MODE(1), .OUT_REG(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_be(req_be[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: word array per instance plus "known contents" flags (array is not reset).
    logic [DW-1:0] mem_m  [2][DEPTH];
    bit            init_m [2][DEPTH];
    logic [DW:0]   q0[$];
    logic [DW:0]   q1[$];

    logic [1:0]         acc_s;
    logic [1:0]         rsp_acc_s;
    logic [1:0][DW-1:0] rsp_d_s;
    logic [1:0]         stall_prev;
    logic [1:0][DW-1:0] stall_data;

    task automatic push_exp(input int k, input logic [DW:0] v);
        if (k == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    task automatic pop_exp(input int k, output logic [DW:0] v, output bit ok);
        ok = 1'b0;
        v  = '0;
        if (k == 0) begin
            if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
        end else begin
            if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
        end
    endtask

    task automatic drive(input int k, input logic v, input logic we, input logic [AW-1:0] a,
                         input logic [BW-1:0] be, input logic [DW-1:0] d);
        req_valid[k] = v;
        req_we[k]    = we;
        req_addr[k]  = a;
        req_be[k]    = be;
        req_wdata[k] = d;
    endtask

    // One clock: sample handshakes just before the edge, score responses, update the model.
    task automatic tick();
        logic [DW:0]   e;
        logic [DW-1:0] oldw;
        logic [DW-1:0] neww;
        bit            ok;
        #1;
        for (int k = 0; k < 2; k++) begin
            acc_s[k]     = rst_n && req_valid[k] && req_ready[k];
            rsp_acc_s[k] = rst_n && rsp_valid[k] && rsp_ready[k];
            rsp_d_s[k]   = rsp_rdata[k];
            if (rst_n) begin
                checks++;
                if (req_ready[k] !== !(rsp_valid[k] && !rsp_ready[k])) begin
                    errors++;
                    $display("FAIL req_ready_rule inst%0d cyc%0d: req_ready=%b, required %b", k, cyc,
                             req_ready[k], !(rsp_valid[k] && !rsp_ready[k]));
                end
            end
            if (rst_n && stall_prev[k]) begin
                checks++;
                if (rsp_valid[k] !== 1'b1 || rsp_rdata[k] !== stall_data[k]) begin
                    errors++;
                    $display("FAIL stall_hold inst%0d cyc%0d: valid=%b data=%h, required valid=1 data=%h",
                             k, cyc, rsp_valid[k], rsp_rdata[k], stall_data[k]);
                end
            end
            stall_prev[k] = rst_n && rsp_valid[k] && !rsp_ready[k];
            stall_data[k] = rsp_rdata[k];
            if (!rst_n) begin
                if (k == 0) q0.delete();
                else        q1.delete();
            end
            if (rsp_acc_s[k]) begin
                pop_exp(k, e, ok);
                if (!ok) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_unexpected inst%0d cyc%0d: got response %h, required none", k, cyc, rsp_rdata[k]);
                end else if (e[DW]) begin
                    checks++;
                    if (rsp_rdata[k] !== e[DW-1:0]) begin
                        errors++;
                        $display("FAIL rsp_data inst%0d cyc%0d: got %h, required %h", k, cyc, rsp_rdata[k], e[DW-1:0]);
                    end
                end
            end
            if (acc_s[k]) begin
                oldw = mem_m[k][req_addr[k]];
                neww = oldw;
                for (int b = 0; b < BW; b++) begin
                    if (req_be[k][b]) neww[8*b +: 8] = req_wdata[k][8*b +: 8];
                end
                if (req_we[k]) begin
                    if (k == 1) push_exp(k, {init_m[k][req_addr[k]], oldw});
                    else        push_exp(k, {1'b1, neww});
                    mem_m[k][req_addr[k]]  = neww;
                    init_m[k][req_addr[k]] = 1'b1;
                end else begin
                    push_exp(k, {init_m[k][req_addr[k]], oldw});
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    // Issue one request on instance k with an empty pipe; check acceptance, latency and data.
    task automatic single(input int k, input logic we, input logic [AW-1:0] a, input logic [BW-1:0] be,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp, input string nm);
        int lat;
        rsp_ready[k] = 1'b1;
        drive(k, 1'b1, we, a, be, d);
        tick();
        drive(k, 1'b0, 1'b0, '0, '0, '0);
        checks++;
        if (acc_s[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept inst%0d: accepted=%b, required 1", nm, k, acc_s[k]);
        end
        lat = 1;
        while (rsp_valid[k] !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != 1 + k) begin
            errors++;
            $display("FAIL %s_latency inst%0d: latency=%0d, required %0d", nm, k, lat, 1 + k);
        end
        checks++;
        if (rsp_rdata[k] !== exp) begin
            errors++;
            $display("FAIL %s_data inst%0d: got %h, required %h", nm, k, rsp_rdata[k], exp);
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(k, 1'b0, 1'b0, '0, '0, '0);
            rsp_ready[k] = 1'b1;
        end
        stall_prev = '0;
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rsp_valid[k] !== 1'b0 || rsp_rdata[k] !== '0) begin
                errors++;
                $display("FAIL reset_rsp inst%0d: valid=%b data=%h, required valid=0 data=0", k, rsp_valid[k], rsp_rdata[k]);
            end
        end
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (req_ready[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready inst%0d: req_ready=%b, required 1", k, req_ready[k]);
            end
        end
        tick();
    endtask

    task automatic test_stream(input int k);
        int nacc;
        int nrsp;
        int nt;
        rsp_ready[k] = 1'b1;
        nacc = 0;
        for (int a = 0; a < DEPTH; a++) begin
            drive(k, 1'b1, 1'b1, AW'(a), '1, DW'(a));
            tick();
            if (acc_s[k]) nacc++;
        end
        checks++;
        if (nacc != DEPTH) begin
            errors++;
            $display("FAIL stream_wr_accept inst%0d: accepted %0d, required %0d", k, nacc, DEPTH);
        end
        nacc = 0;
        nrsp = 0;
        nt   = 0;
        for (int a = 0; a < DEPTH; a++) begin
            drive(k, 1'b1, 1'b0, AW'(a), '0, '0);
            tick();
            nt++;
            if (acc_s[k]) nacc++;
            if (rsp_acc_s[k]) nrsp++;
        end
        drive(k, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 1 + k; i++) begin
            tick();
            nt++;
            if (rsp_acc_s[k]) nrsp++;
        end
        checks++;
        if (nacc != DEPTH) begin
            errors++;
            $display("FAIL stream_rd_accept inst%0d: accepted %0d, required %0d", k, nacc, DEPTH);
        end
        checks++;
        if (nrsp != nt) begin
            errors++;
            $display("FAIL stream_rsp_per_cycle inst%0d: %0d responses in %0d cycles, required %0d", k, nrsp, nt, nt);
        end
        checks++;
        if (rsp_valid[k] !== 1'b0) begin
            errors++;
            $display("FAIL stream_drained inst%0d: rsp_valid=%b, required 0", k, rsp_valid[k]);
        end
    endtask

    task automatic test_write_read(input int k);
        logic [DW-1:0] d;
        d = 64'h1122334455667788;
        single(k, 1'b1, AW'(5), '1, d, (k == 0) ? d : mem_m[k][5], "wr_full");
        single(k, 1'b0, AW'(5), '0, '0, d, "rd_full");
    endtask

    task automatic test_be_merge(input int k);
        single(k, 1'b1, AW'(5), 8'h0F, 64'hAAAAAAAAAAAAAAAA,
               (k == 0) ? 64'h11223344AAAAAAAA : 64'h1122334455667788, "be_merge_wr");
        single(k, 1'b0, AW'(5), '0, '0, 64'h11223344AAAAAAAA, "be_merge_rd");
    endtask

    task automatic test_noop(input int k);
        single(k, 1'b1, AW'(7), '1, 64'h55, (k == 0) ? 64'h55 : mem_m[k][7], "noop_prep");
        single(k, 1'b1, AW'(7), 8'h00, '1, 64'h55, "noop_wr");
        single(k, 1'b0, AW'(7), '0, '0, 64'h55, "noop_rd");
    endtask

    task automatic test_backpressure(input int k);
        logic [DW-1:0] v   [4];
        logic [DW-1:0] got [4];
        int  nx;
        int  n;
        bit  sawlow;
        for (int i = 0; i < 4; i++) begin
            v[i] = {$urandom, $urandom};
            single(k, 1'b1, AW'(i), '1, v[i], (k == 0) ? v[i] : mem_m[k][i], "bp_prep");
        end
        nx = 0;
        n = 0;
        sawlow = 1'b0;
        for (int c = 0; c < 20; c++) begin
            rsp_ready[k] = (c < 2 || c > 5);
            if (nx < 4) drive(k, 1'b1, 1'b0, AW'(nx), '0, '0);
            else        drive(k, 1'b0, 1'b0, '0, '0, '0);
            #1;
            if (!req_ready[k]) sawlow = 1'b1;
            tick();
            if (acc_s[k]) nx++;
            if (rsp_acc_s[k]) begin
                if (n < 4) got[n] = rsp_d_s[k];
                n++;
            end
        end
        rsp_ready[k] = 1'b1;
        checks++;
        if (!sawlow) begin
            errors++;
            $display("FAIL bp_ready_drop inst%0d: req_ready never low, required low during stall", k);
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL bp_count inst%0d: %0d responses, required 4", k, n);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                checks++;
                if (got[i] !== v[i]) begin
                    errors++;
                    $display("FAIL bp_order inst%0d rsp%0d: got %h, required %h", k, i, got[i], v[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] w;
        int nv;
        for (int k = 0; k < 2; k++) rsp_ready[k] = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 2; k++) drive(k, 1'b1, 1'b0, AW'(r), '0, '0);
            tick();
        end
        for (int k = 0; k < 2; k++) drive(k, 1'b0, 1'b0, '0, '0, '0);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (rsp_valid[k] !== 1'b0 || rsp_rdata[k] !== '0) begin
                errors++;
                $display("FAIL mid_reset_rsp inst%0d: valid=%b data=%h, required valid=0 data=0", k, rsp_valid[k], rsp_rdata[k]);
            end
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            nv = 0;
            for (int i = 0; i < 4; i++) begin
                tick();
                if (rsp_valid[k]) nv++;
            end
            checks++;
            if (nv != 0) begin
                errors++;
                $display("FAIL mid_reset_stale inst%0d: %0d stale valid cycles, required 0", k, nv);
            end
        end
        w = {$urandom, $urandom};
        for (int k = 0; k < 2; k++) drive(k, 1'b1, 1'b1, AW'(20), '1, w);
        tick();
        for (int k = 0; k < 2; k++) drive(k, 1'b0, 1'b0, '0, '0, '0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            single(k, 1'b0, AW'(20), '0, '0, w, "persist_rd");
            single(k, 1'b0, AW'(5), '0, '0, 64'h11223344AAAAAAAA, "persist_old_rd");
        end
    endtask

    task automatic test_random(input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            for (int k = 0; k < 2; k++) begin
                rsp_ready[k] = ($urandom_range(0, 3) != 0);
                drive(k, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                      BW'($urandom_range(0, 255)), {$urandom, $urandom});
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            drive(k, 1'b0, 1'b0, '0, '0, '0);
            rsp_ready[k] = 1'b1;
        end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL random_drain: outstanding %0d/%0d responses, required 0/0", q0.size(), q1.size());
        end
        checks++;
        if (rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL random_idle: rsp_valid=%b, required 00", rsp_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < DEPTH; a++) begin
                mem_m[k][a]  = '0;
                init_m[k][a] = 1'b0;
            end
        end
        test_reset();
        for (int k = 0; k < 2; k++) test_stream(k);
        for (int k = 0; k < 2; k++) test_write_read(k);
        for (int k = 0; k < 2; k++) test_be_merge(k);
        for (int k = 0; k < 2; k++) test_noop(k);
        for (int k = 0; k < 2; k++) test_backpressure(k);
        test_reset_mid();
        test_random(400);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
